// File: rtl/muldiv_ctrl_if.sv
// Port bundle between the EX stage (master) and the HI/LO multiply/divide
// sequencer (slave).
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hilo_rd;
    logic             flush;
    logic             busy;
    logic             stall_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             done;

    modport master (
        output start, op, a, b, hilo_rd, flush,
        input  busy, stall_req, hi, lo, done
    );

    modport slave (
        input  start, op, a, b, hilo_rd, flush,
        output busy, stall_req, hi, lo, done
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide sequencer: 1-bit-per-cycle shift-add
// multiplier and restoring divider, owns HI/LO and requests pipeline stalls.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_ctrl_if.slave bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;        // MUL: {partial, multiplier}; DIV: {remainder, quotient}
    logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
    logic               is_div;
    logic               div_zero_q;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               busy;

    // Instruction decode
    logic             op_mul;
    logic             op_div;
    logic             op_signed;
    logic             op_muldiv;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             div_zero;
    logic             accept;

    always_comb begin
        op_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
        op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        op_muldiv = op_mul || op_div;
        sign_a    = op_signed & bus.a[WIDTH-1];
        sign_b    = op_signed & bus.b[WIDTH-1];
        mag_a     = sign_a ? -bus.a : bus.a;
        mag_b     = sign_b ? -bus.b : bus.b;
        div_zero  = op_div && (bus.b == '0);
        accept    = (state == IDLE) && bus.start && !bus.flush;
    end

    // One iteration of each algorithm
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] div_nxt;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & opnd};
        mul_nxt  = {mul_sum, acc[WIDTH-1:1]};
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        // rem_sh never exceeds 2*divisor-1, so the borrow bit is an exact compare
        rem_diff = rem_sh - {1'b0, opnd};
        div_nxt  = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        if (!rem_diff[WIDTH])
            div_nxt = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    // Sign correction applied on the FIX edge
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && op_muldiv)
                    state_nxt = div_zero ? FIX : CALC;
            end
            CALC: begin
                if (bus.flush)
                    state_nxt = IDLE;
                else if (count == LAST)
                    state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            acc        <= '0;
            opnd       <= '0;
            is_div     <= 1'b0;
            div_zero_q <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.op == OP_MTHI) hi_q <= bus.a;
                        if (bus.op == OP_MTLO) lo_q <= bus.a;
                        if (op_muldiv) begin
                            count      <= '0;
                            is_div     <= op_div;
                            div_zero_q <= div_zero;
                            neg_q      <= sign_a ^ sign_b;
                            neg_r      <= sign_a;
                            if (div_zero) begin
                                // raw dividend parked in the upper half becomes HI
                                acc  <= {bus.a, {WIDTH{1'b0}}};
                                opnd <= '0;
                            end else if (op_div) begin
                                acc  <= {{WIDTH{1'b0}}, mag_a};
                                opnd <= mag_b;
                            end else begin
                                acc  <= {{WIDTH{1'b0}}, mag_b};
                                opnd <= mag_a;
                            end
                        end
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        count <= count + CW'(1);
                        acc   <= is_div ? div_nxt : mul_nxt;
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        done_q <= 1'b1;
                        if (div_zero_q) begin
                            hi_q <= acc[2*WIDTH-1:WIDTH];
                            lo_q <= '1;
                        end else if (is_div) begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign bus.busy      = busy;
    assign bus.stall_req = busy & (bus.start | bus.hilo_rd);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed vectors plus randomized ops checked against
// an integer-arithmetic HI/LO model.
module tb_muldiv_ctrl;
    localparam int W = 32;
    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3, MTHI = 3'd4, MTLO = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    muldiv_ctrl_if #(.WIDTH(W)) bus ();
    muldiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Architectural effect of one HI/LO instruction on the model registers.
    function automatic void model_apply(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [2*W-1:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            MULT:  begin p = sa * sb; {m_hi, m_lo} = p; end
            MULTU: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
            DIV: begin
                if (b == 0) begin m_hi = a; m_lo = '1; end
                else begin q = sa / sb; r = sa % sb; m_lo = q[W-1:0]; m_hi = r[W-1:0]; end
            end
            DIVU: begin
                if (b == 0) begin m_hi = a; m_lo = '1; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            MTHI: m_hi = a;
            MTLO: m_lo = a;
            default: ;
        endcase
    endfunction

    // Present one instruction for one edge; returns at the following negedge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Count busy cycles and done pulses until idle, plus one extra cycle.
    task automatic wait_idle(output int bcyc, output int dn);
        bcyc = 0; dn = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.done) dn++;
            if (!bus.busy) break;
            bcyc++;
            @(negedge clk);
        end
        @(negedge clk);
        if (bus.done) dn++;
    endtask

    task automatic test_reset();
        bus.hilo_rd = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall_req); end
        checks++; if (bus.hi !== '0) begin errors++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
        checks++; if (bus.lo !== '0) begin errors++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        rst = 1'b0;
        bus.hilo_rd = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_directed();
        logic [2:0]   d_op [5] = '{MULT, MULTU, DIV, DIVU, DIV};
        logic [W-1:0] d_a  [5] = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h9, 32'h80000000};
        logic [W-1:0] d_b  [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h2, 32'h0, 32'hFFFFFFFF};
        logic [W-1:0] d_hi [5] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h9, 32'h0};
        logic [W-1:0] d_lo [5] = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
        int           d_bc [5] = '{33, 33, 33, 1, 33};
        int bc, dn;
        for (int i = 0; i < 5; i++) begin
            issue(d_op[i], d_a[i], d_b[i]);
            wait_idle(bc, dn);
            m_hi = d_hi[i]; m_lo = d_lo[i];
            checks++; if (bc != d_bc[i]) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bc, d_bc[i]); end
            checks++; if (dn != 1) begin errors++; $display("FAIL dir%0d_done_pulses: got %0d want 1", i, dn); end
            checks++; if (bus.hi !== d_hi[i]) begin errors++; $display("FAIL dir%0d_hi: got %h want %h", i, bus.hi, d_hi[i]); end
            checks++; if (bus.lo !== d_lo[i]) begin errors++; $display("FAIL dir%0d_lo: got %h want %h", i, bus.lo, d_lo[i]); end
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [W-1:0] a, b;
        int bc, dn, exp_bc;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 5));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = $urandom_range(1, 15);
                default: ;
            endcase
            issue(op, a, b);
            model_apply(op, a, b);
            if (op <= DIVU) begin
                wait_idle(bc, dn);
                exp_bc = ((op == DIV || op == DIVU) && b == 0) ? 1 : W + 1;
                checks++; if (bc != exp_bc) begin errors++; $display("FAIL rnd%0d_busy_cycles op%0d: got %0d want %0d", i, op, bc, exp_bc); end
                checks++; if (dn != 1) begin errors++; $display("FAIL rnd%0d_done_pulses: got %0d want 1", i, dn); end
            end else begin
                checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rnd%0d_mt_busy_done: got %b%b want 00", i, bus.busy, bus.done); end
            end
            checks++; if (bus.hi !== m_hi) begin errors++; $display("FAIL rnd%0d_hi op%0d a=%h b=%h: got %h want %h", i, op, a, b, bus.hi, m_hi); end
            checks++; if (bus.lo !== m_lo) begin errors++; $display("FAIL rnd%0d_lo op%0d a=%h b=%h: got %h want %h", i, op, a, b, bus.lo, m_lo); end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] a, b, x;
        int nst;
        a = $urandom; b = $urandom;
        issue(MULT, a, b);
        model_apply(MULT, a, b);
        bus.hilo_rd = 1'b1;
        #1;
        nst = 0;
        for (int i = 0; i < 200; i++) begin
            if (!bus.busy) break;
            if (bus.stall_req) nst++;
            @(negedge clk);
        end
        checks++; if (nst != W + 1) begin errors++; $display("FAIL stall_cycles: got %0d want %0d", nst, W + 1); end
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", bus.stall_req); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", bus.done); end
        checks++; if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL stall_result: got %h_%h want %h_%h", bus.hi, bus.lo, m_hi, m_lo); end
        @(negedge clk);
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL idle_hilo_rd_stall: got %b want 0", bus.stall_req); end
        bus.hilo_rd = 1'b0;
        // Reserved op codes must leave everything untouched.
        x = $urandom;
        bus.start = 1'b1; bus.op = 3'd6; bus.a = x; bus.b = x;
        @(negedge clk);
        bus.op = 3'd7;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL op67_busy: got %b want 0", bus.busy); end
        checks++; if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL op67_hilo: got %h_%h want %h_%h", bus.hi, bus.lo, m_hi, m_lo); end
    endtask

    task automatic test_held_start();
        logic [W-1:0] a, b, x;
        int nst;
        a = $urandom; b = $urandom; x = $urandom;
        issue(MULTU, a, b);
        model_apply(MULTU, a, b);
        bus.start = 1'b1; bus.op = MTHI; bus.a = x;
        #1;
        nst = 0;
        for (int i = 0; i < 200; i++) begin
            if (!bus.busy) break;
            if (bus.stall_req) nst++;
            @(negedge clk);
        end
        checks++; if (nst != W + 1) begin errors++; $display("FAIL held_stall_cycles: got %0d want %0d", nst, W + 1); end
        checks++; if (bus.hi !== m_hi) begin errors++; $display("FAIL held_hi_before: got %h want %h", bus.hi, m_hi); end
        @(negedge clk);
        bus.start = 1'b0;
        model_apply(MTHI, x, '0);
        checks++; if (bus.hi !== m_hi) begin errors++; $display("FAIL held_mthi: got %h want %h", bus.hi, m_hi); end
        checks++; if (bus.lo !== m_lo) begin errors++; $display("FAIL held_lo: got %h want %h", bus.lo, m_lo); end
    endtask

    task automatic test_flush();
        logic [W-1:0] a, b;
        int dn;
        a = $urandom; b = $urandom | 32'h1;
        issue(DIV, a, b);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_calc_busy: got %b want 0", bus.busy); end
        dn = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.done) dn++;
            @(negedge clk);
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL flush_calc_done: got %0d want 0", dn); end
        checks++; if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL flush_calc_hilo: got %h_%h want %h_%h", bus.hi, bus.lo, m_hi, m_lo); end
        // Divide by zero sits in FIX for one cycle; flush it there.
        issue(DIVU, 32'h5, '0);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL flush_fix_busy_done: got %b%b want 00", bus.busy, bus.done); end
        checks++; if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL flush_fix_hilo: got %h_%h want %h_%h", bus.hi, bus.lo, m_hi, m_lo); end
        // Flush in IDLE discards the concurrent start.
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = MTLO; bus.a = ~m_lo;
        @(negedge clk);
        bus.op = MULT; bus.a = $urandom; bus.b = $urandom;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        checks++; if (bus.lo !== m_lo) begin errors++; $display("FAIL flush_idle_mtlo: got %h want %h", bus.lo, m_lo); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle_mult_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] x, y;
        x = $urandom | 32'h1; y = $urandom | 32'h1;
        issue(MTHI, x, '0);
        issue(MTLO, y, '0);
        model_apply(MTHI, x, '0);
        model_apply(MTLO, y, '0);
        checks++; if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL mt_pair: got %h_%h want %h_%h", bus.hi, bus.lo, m_hi, m_lo); end
        issue(MULT, $urandom, $urandom);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        m_hi = '0; m_lo = '0;
        checks++; if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL rst_mid_hilo: got %h_%h want 0", bus.hi, bus.lo); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_after: got %b%b want 00", bus.busy, bus.done); end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        bus.hilo_rd = 1'b0; bus.flush = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_held_start();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
